ddr3_writer_frame_linear: RTL

Avalon-MM write master that stores one grayscale camera frame into DDR3 in row-major, contiguous order, forming the producer side of the frame buffer that the column-wise DDR3 reader consumes. Accepts 256-bit pixel words (16 pixels at 16 bit) on a valid/ready stream tagged with SOF/EOF. Frame-locks on SOF, counts lines and words, and issues one single-beat write per word. Reports frame completion and any framing error.

---
 rtl/ddr3_frame_pkg.sv | 30 +++
 rtl/ddr3_writer_frame_linear_if.sv | 45 ++++
 rtl/frame_position_counter.sv | 64 ++++++
 rtl/ddr3_writer_frame_linear.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ddr3_frame_pkg.sv
// Types and constants shared by the DDR3 frame-buffer writer and the
// column-wise reader that consumes the same memory layout.
package ddr3_frame_pkg;

    localparam int DATA_W  = 256;
    localparam int ADDR_W  = 27;
    localparam int BE_W    = DATA_W / 8;
    localparam int BURST_W = 4;

    // Info-bit positions used when SOF/EOF travel alongside pixel words.
    localparam int INFO_SOF_BIT = 0;
    localparam int INFO_EOF_BIT = 1;
    localparam int INFO_W       = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_RUN,
        ST_DRAIN
    } wr_state_e;

    function automatic int pixels_per_wr(input int in_width);
        return DATA_W / in_width;
    endfunction

    function automatic int words_per_line(input int frame_full_width, input int in_width);
        return frame_full_width / pixels_per_wr(in_width);
    endfunction

endpackage

// File: rtl/ddr3_writer_frame_linear_if.sv
// Start/status handshake, pixel stream and Avalon-MM write bus of the frame writer.
interface ddr3_writer_frame_linear_if;
    import ddr3_frame_pkg::*;

    logic [ADDR_W-1:0]  start_data;
    logic               start_valid;
    logic               start_ready;

    logic [DATA_W-1:0]  in_data;
    logic               in_sof;
    logic               in_eof;
    logic               in_valid;
    logic               in_ready;

    logic [ADDR_W-1:0]  ddr3_address;
    logic [DATA_W-1:0]  ddr3_writedata;
    logic [BE_W-1:0]    ddr3_byteenable;
    logic [BURST_W-1:0] ddr3_burstcount;
    logic               ddr3_write;
    logic               ddr3_waitrequest;

    logic               frame_done;
    logic               sync_error;

    modport master (
        input  start_data, start_valid,
        output start_ready,
        input  in_data, in_sof, in_eof, in_valid,
        output in_ready,
        output ddr3_address, ddr3_writedata, ddr3_byteenable, ddr3_burstcount, ddr3_write,
        input  ddr3_waitrequest,
        output frame_done, sync_error
    );

    modport slave (
        output start_data, start_valid,
        input  start_ready,
        output in_data, in_sof, in_eof, in_valid,
        input  in_ready,
        input  ddr3_address, ddr3_writedata, ddr3_byteenable, ddr3_burstcount, ddr3_write,
        output ddr3_waitrequest,
        input  frame_done, sync_error
    );

endinterface

// File: rtl/frame_position_counter.sv
// Line/column position inside a frame plus the running linear word offset,
// so the write address never needs a line*width multiply.
module frame_position_counter #(
    parameter int LINES = 480,
    parameter int WPL   = 48,
    parameter int OFF_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             restart_i,
    input  logic             advance_i,
    output logic [OFF_W-1:0] offset_o,
    output logic             is_last_o
);
    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int COL_W  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WPL - 1);

    logic [LINE_W-1:0] line_q, line_d, line_b;
    logic [COL_W-1:0]  col_q, col_d, col_b;
    logic [OFF_W-1:0]  offset_q, offset_d, offset_b;

    always_comb begin
        // Restart behaves as "go to word 0, then step past it" in the same cycle.
        line_b   = restart_i ? '0 : line_q;
        col_b    = restart_i ? '0 : col_q;
        offset_b = restart_i ? '0 : offset_q;
        line_d   = line_b;
        col_d    = col_b;
        offset_d = offset_b;
        if (advance_i) begin
            offset_d = offset_b + OFF_W'(1);
            if (col_b == LAST_COL) begin
                col_d  = '0;
                line_d = (line_b == LAST_LINE) ? '0 : line_b + LINE_W'(1);
            end else begin
                col_d = col_b + COL_W'(1);
            end
        end
        if (clear_i) begin
            line_d   = '0;
            col_d    = '0;
            offset_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_q   <= '0;
            col_q    <= '0;
            offset_q <= '0;
        end else begin
            line_q   <= line_d;
            col_q    <= col_d;
            offset_q <= offset_d;
        end
    end

    assign offset_o  = offset_q;
    assign is_last_o = (line_q == LAST_LINE) && (col_q == LAST_COL);

endmodule

// File: rtl/ddr3_writer_frame_linear.sv
// Avalon-MM write master: stores one row-major frame from a base word address,
// one single-beat write per 256-bit pixel word, with frame-lock on SOF.
module ddr3_writer_frame_linear
    import ddr3_frame_pkg::*;
#(
    parameter int in_width         = 16,
    parameter int frame_lines      = 480,
    parameter int frame_full_width = 768
) (
    input  logic                       ddr3clk,
    input  logic                       ddr3clk_reset_n,
    ddr3_writer_frame_linear_if.master bus
);
    localparam int WORDS_PER_LINE = words_per_line(frame_full_width, in_width);
    localparam bit SINGLE_WORD    = (frame_lines * WORDS_PER_LINE) == 1;

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_pending_q, wr_pending_d;
    logic              sync_error_q, sync_error_d;
    logic              frame_done_q, frame_done_d;

    logic              in_ready, load, write_done, word_last;
    logic [ADDR_W-1:0] word_offset, pos_offset;
    logic              pos_clear, pos_restart, pos_advance, pos_is_last;

    frame_position_counter #(
        .LINES (frame_lines),
        .WPL   (WORDS_PER_LINE),
        .OFF_W (ADDR_W)
    ) u_pos (
        .clk       (ddr3clk),
        .rst_n     (ddr3clk_reset_n),
        .clear_i   (pos_clear),
        .restart_i (pos_restart),
        .advance_i (pos_advance),
        .offset_o  (pos_offset),
        .is_last_o (pos_is_last)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        base_d       = base_q;
        wr_pending_d = wr_pending_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        sync_error_d = sync_error_q;
        frame_done_d = 1'b0;
        pos_clear    = 1'b0;
        pos_restart  = 1'b0;
        pos_advance  = 1'b0;
        in_ready     = 1'b0;
        load         = 1'b0;
        word_offset  = pos_offset;
        word_last    = pos_is_last;
        write_done   = wr_pending_q && !bus.ddr3_waitrequest;

        if (write_done) wr_pending_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    base_d       = bus.start_data;
                    sync_error_d = 1'b0;
                    pos_clear    = 1'b1;
                    state_d      = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                in_ready = 1'b1;
                load     = bus.in_valid && bus.in_sof;
            end
            ST_RUN: begin
                in_ready = !wr_pending_q || !bus.ddr3_waitrequest;
                load     = bus.in_valid && in_ready;
                // A stray SOF re-locks the frame: this word is written as word 0 at the base.
                if (load && bus.in_sof) begin
                    sync_error_d = 1'b1;
                    pos_restart  = 1'b1;
                    word_offset  = '0;
                    word_last    = SINGLE_WORD;
                end
            end
            ST_DRAIN: begin
                if (!wr_pending_q || write_done) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            wr_pending_d = 1'b1;
            wr_addr_d    = base_q + word_offset;
            wr_data_d    = bus.in_data;
            pos_advance  = 1'b1;
            if (bus.in_eof != word_last) sync_error_d = 1'b1;
            state_d = word_last ? ST_DRAIN : ST_RUN;
        end
    end

    always_ff @(posedge ddr3clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!ddr3clk_reset_n) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            wr_pending_q <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            sync_error_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            wr_pending_q <= wr_pending_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            sync_error_q <= sync_error_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.start_ready     = (state_q == ST_IDLE);
    assign bus.in_ready        = in_ready;
    assign bus.ddr3_write      = wr_pending_q;
    assign bus.ddr3_address    = wr_addr_q;
    assign bus.ddr3_writedata  = wr_data_q;
    assign bus.ddr3_byteenable = '1;
    assign bus.ddr3_burstcount = BURST_W'(1);
    assign bus.frame_done      = frame_done_q;
    assign bus.sync_error      = sync_error_q;

endmodule
